// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings for the MIPS next-PC path: next-PC
//               operations, branch-unit state codes and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Next-PC operation selector, produced by decode.
  typedef logic [1:0] npc_op_t;

  localparam npc_op_t NPC_PC4    = 2'd0;
  localparam npc_op_t NPC_BRANCH = 2'd1;
  localparam npc_op_t NPC_J      = 2'd2;
  localparam npc_op_t NPC_JR     = 2'd3;

  // Branch-unit states: NORMAL fetches sequentially, DELAY is the delay slot
  // during which a latched redirect target is pending.
  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_DELAY  = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/npc_calc.sv
`default_nettype none
// ============================================================================
// Module      : npc_calc
// Description : Combinational redirect-target computation. Produces pc+4,
//               the redirect target for the current npcOp, whether the
//               redirect is taken, and whether a JR target is misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module npc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npcOp,
  input  logic        cmpRes,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rsData,
  output logic [31:0] pc_plus4,
  output logic [31:0] target,
  output logic        taken,
  output logic        misaligned
);

  logic [31:0] br_offset;

  // Word offset sign-extended and scaled to bytes.
  assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc_plus4  = pc + 32'd4;

  // Select target and taken condition for the decoded operation.
  always_comb begin
    target     = pc_plus4;
    taken      = 1'b0;
    misaligned = 1'b0;
    case (npcOp)
      NPC_BRANCH: begin
        target = pc_plus4 + br_offset;
        taken  = cmpRes;
      end
      NPC_J: begin
        target = {pc_plus4[31:28], imm26, 2'b00};
        taken  = 1'b1;
      end
      NPC_JR: begin
        // Low bits are cleared and the target still used; the error is flagged.
        target     = {rsData[31:2], 2'b00};
        taken      = 1'b1;
        misaligned = |rsData[1:0];
      end
      default: begin
        target = pc_plus4;
        taken  = 1'b0;
      end
    endcase
  end

endmodule : npc_calc
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Program-counter register and branch resolver. Applies taken
//               redirects either after one delay-slot instruction or
//               immediately, and flags misaligned JR targets.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npcOp,
  input  logic        cmpRes,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rsData,
  output logic [31:0] pc,
  output logic [31:0] linkAddr,
  output logic        addrErr
);

  logic [0:0]  state;
  logic [31:0] tgt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        taken;
  logic        misaligned;

  npc_calc u_npc_calc (
    .pc         (pc),
    .npcOp      (npcOp),
    .cmpRes     (cmpRes),
    .imm16      (imm16),
    .imm26      (imm26),
    .rsData     (rsData),
    .pc_plus4   (pc_plus4),
    .target     (target),
    .taken      (taken),
    .misaligned (misaligned)
  );

  // Return address skips the delay slot when one exists.
  assign linkAddr = pc + (DELAY_SLOT ? 32'd8 : 32'd4);

  // PC, delay-slot FSM and address-error pulse; everything holds under stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      state   <= ST_NORMAL;
      tgt     <= 32'd0;
      addrErr <= 1'b0;
    end else begin
      addrErr <= 1'b0;
      if (!stall) begin
        if (DELAY_SLOT) begin
          if (state == ST_DELAY) begin
            // Delay slot done: npcOp is ignored here, so a branch in the slot is dropped.
            pc    <= tgt;
            state <= ST_NORMAL;
          end else begin
            pc      <= pc_plus4;
            addrErr <= misaligned;
            if (taken) begin
              tgt   <= target;
              state <= ST_DELAY;
            end
          end
        end else begin
          pc      <= taken ? target : pc_plus4;
          addrErr <= misaligned;
        end
      end
    end
  end

endmodule : pc_branch_unit
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Scoreboard bench for pc_branch_unit. One instance with a
//               delay slot, one without; directed vectors push expected
//               pc/addrErr values and a monitor compares them after each edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

  localparam logic [1:0] OP_PC4 = 2'd0;
  localparam logic [1:0] OP_BR  = 2'd1;
  localparam logic [1:0] OP_J   = 2'd2;
  localparam logic [1:0] OP_JR  = 2'd3;

  logic        clk;
  logic        reset;

  logic        stall1, cmp1;
  logic [1:0]  op1;
  logic [15:0] imm16_1;
  logic [25:0] imm26_1;
  logic [31:0] rs1, pc1, link1;
  logic        err1;

  logic        stall0, cmp0;
  logic [1:0]  op0;
  logic [15:0] imm16_0;
  logic [25:0] imm26_0;
  logic [31:0] rs0, pc0, link0;
  logic        err0;

  typedef struct {
    int          dut;
    logic [31:0] pc;
    logic        err;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;
  event drain_ev;

  pc_branch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b1)) u_ds1 (
    .clk(clk), .reset(reset), .stall(stall1), .npcOp(op1), .cmpRes(cmp1),
    .imm16(imm16_1), .imm26(imm26_1), .rsData(rs1),
    .pc(pc1), .linkAddr(link1), .addrErr(err1)
  );

  pc_branch_unit #(.RESET_PC(32'h0000_3000), .DELAY_SLOT(1'b0)) u_ds0 (
    .clk(clk), .reset(reset), .stall(stall0), .npcOp(op0), .cmpRes(cmp0),
    .imm16(imm16_0), .imm26(imm26_0), .rsData(rs0),
    .pc(pc0), .linkAddr(link0), .addrErr(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Pop every pending expectation and compare with the matching instance.
  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.dut == 1) begin
        check({e.tag, "/ds1.pc"},   pc1,  e.pc);
        check({e.tag, "/ds1.link"}, link1, e.pc + 32'd8);
        check({e.tag, "/ds1.err"},  {31'd0, err1}, {31'd0, e.err});
      end else begin
        check({e.tag, "/ds0.pc"},   pc0,  e.pc);
        check({e.tag, "/ds0.link"}, link0, e.pc + 32'd4);
        check({e.tag, "/ds0.err"},  {31'd0, err0}, {31'd0, e.err});
      end
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge, and on
  // demand for asynchronous-reset checks.
  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        drain();
      end
      forever begin
        @(drain_ev);
        drain();
      end
    join
  end

  task automatic exp1(input string tag, input logic [31:0] p, input logic e);
    exp_t x;
    x.dut = 1; x.pc = p; x.err = e; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic exp0(input string tag, input logic [31:0] p, input logic e);
    exp_t x;
    x.dut = 0; x.pc = p; x.err = e; x.tag = tag;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    stall1 = 1'b0; op1 = OP_PC4; cmp1 = 1'b0; imm16_1 = 16'd0; imm26_1 = 26'd0; rs1 = 32'd0;
    stall0 = 1'b0; op0 = OP_PC4; cmp0 = 1'b0; imm16_0 = 16'd0; imm26_0 = 26'd0; rs0 = 32'd0;
  endtask

  // Asynchronous reset, checked before any clock edge, released at the next negedge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    exp1("reset", 32'h0000_3000, 1'b0);
    exp0("reset", 32'h0000_3000, 1'b0);
    ->drain_ev;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    idle();
    #2;

    // Sequential fetch.
    do_reset();
    exp1("seq1", 32'h0000_3004, 1'b0); tick();
    exp1("seq2", 32'h0000_3008, 1'b0); tick();
    exp1("seq3", 32'h0000_300C, 1'b0); tick();

    // Taken backward branch; a taken branch in the delay slot is ignored.
    do_reset();
    tick(); tick();
    op1 = OP_BR; cmp1 = 1'b1; imm16_1 = 16'hFFFE;
    exp1("br_t_slot", 32'h0000_300C, 1'b0); tick();
    exp1("br_t_tgt",  32'h0000_3004, 1'b0); tick();
    // Not-taken branch at 0x3008.
    op1 = OP_PC4; cmp1 = 1'b0;
    exp1("br_nt_pre", 32'h0000_3008, 1'b0); tick();
    op1 = OP_BR; cmp1 = 1'b0; imm16_1 = 16'hFFFE;
    exp1("br_nt_1", 32'h0000_300C, 1'b0); tick();
    op1 = OP_PC4;
    exp1("br_nt_2", 32'h0000_3010, 1'b0); tick();

    // Misaligned JR: one-cycle addrErr pulse, target with low bits cleared.
    do_reset();
    op1 = OP_JR; rs1 = 32'h0000_4002;
    exp1("jr_slot", 32'h0000_3004, 1'b1); tick();
    op1 = OP_PC4; rs1 = 32'd0;
    exp1("jr_tgt",  32'h0000_4000, 1'b0); tick();
    exp1("jr_next", 32'h0000_4004, 1'b0); tick();

    // J with the delay slot stretched by stall.
    do_reset();
    op1 = OP_J; imm26_1 = 26'h0000100;
    exp1("j_slot", 32'h0000_3004, 1'b0); tick();
    op1 = OP_PC4; imm26_1 = 26'd0; stall1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp1("j_stall", 32'h0000_3004, 1'b0); tick();
    end
    stall1 = 1'b0;
    exp1("j_tgt", 32'h0000_0400, 1'b0); tick();
    // Stalled misaligned JR in NORMAL: nothing moves, no error pulse.
    stall1 = 1'b1; op1 = OP_JR; rs1 = 32'h0000_0001;
    exp1("stall_jr", 32'h0000_0400, 1'b0); tick();
    stall1 = 1'b0; op1 = OP_PC4; rs1 = 32'd0;
    exp1("stall_rel", 32'h0000_0404, 1'b0); tick();

    // Reset in the middle of a delay slot discards the pending target.
    do_reset();
    op1 = OP_JR; rs1 = 32'h0000_4000;
    exp1("rd_slot", 32'h0000_3004, 1'b0); tick();
    op1 = OP_PC4; rs1 = 32'd0;
    reset = 1'b1;
    #1;
    exp1("rd_async", 32'h0000_3000, 1'b0);
    ->drain_ev;
    #1;
    reset = 1'b0;
    exp1("rd_after1", 32'h0000_3004, 1'b0); tick();
    exp1("rd_after2", 32'h0000_3008, 1'b0); tick();

    // No delay slot: immediate redirects and 32-bit wrap-around.
    do_reset();
    op0 = OP_BR; cmp0 = 1'b1; imm16_0 = 16'h0001;
    exp0("ds0_br", 32'h0000_3008, 1'b0); tick();
    op0 = OP_JR; cmp0 = 1'b0; rs0 = 32'hFFFF_FFFC;
    exp0("ds0_jr", 32'hFFFF_FFFC, 1'b0); tick();
    op0 = OP_PC4; rs0 = 32'd0;
    exp0("ds0_wrap", 32'h0000_0000, 1'b0); tick();
    op0 = OP_J; imm26_0 = 26'h3FFFFFF;
    exp0("ds0_j", 32'h0FFF_FFFC, 1'b0); tick();
    op0 = OP_JR; imm26_0 = 26'd0; rs0 = 32'h0000_0013;
    exp0("ds0_jr_mis", 32'h0000_0010, 1'b1); tick();
    op0 = OP_PC4; rs0 = 32'd0;
    exp0("ds0_clr", 32'h0000_0014, 1'b0); tick();

    idle();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_empty: got %0d pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pc_branch_unit
`default_nettype wire
